// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-dump streamer: default bus geometry,
// FSM state codes and the flat-bus word extractor.
// Optional feature macro: REG_DUMP_CHECKSUM_EN (adds the CSUM state).
package reg_dump_pkg;

  // Default geometry of the CPU debug bus
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned DATA_W_DEF   = 32;

  // Upper bounds handled by bus_word(); larger buses need these raised
  localparam int unsigned MAX_BUS_W  = 4096;
  localparam int unsigned MAX_WORD_W = 64;

  // FSM state encoding
  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SCAN   = 3'd1;
  localparam state_t ST_SEND   = 3'd2;
  localparam state_t ST_FINISH = 3'd3;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam state_t ST_CSUM   = 3'd4;
`endif

  // Word idx of a flat bus with width-bit words; caller truncates to its width
  function automatic logic [MAX_WORD_W-1:0] bus_word(input logic [MAX_BUS_W-1:0] bus,
                                                     input int unsigned idx,
                                                     input int unsigned width);
    return MAX_WORD_W'(bus >> (idx * width));
  endfunction

endpackage

// File: rtl/reg_dump_snapshot.sv
// Snapshot store for the register dump: NUM_REGS x DATA_W capture register,
// indexed read port and (with REG_DUMP_CHECKSUM_EN) the XOR of all words.
module reg_dump_snapshot
  import reg_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       capture,
  input  logic [NUM_REGS*DATA_W-1:0] reg_debug,
  input  logic [IDX_W-1:0]           rd_index,
  output logic [DATA_W-1:0]          rd_data
`ifdef REG_DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]          csum
`endif
);

  localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_W-1:0] snap [NUM_REGS];

  // Capture every word of the debug bus in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) snap[i] <= '0;
    end else if (capture) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        snap[i] <= DATA_W'(bus_word(MAX_BUS_W'(reg_debug), i, DATA_W));
    end
  end

  // Read mux; the index is only ever driven with values below NUM_REGS
  assign rd_data = snap[SEL_W'(rd_index)];

`ifdef REG_DUMP_CHECKSUM_EN
  // XOR reduction over the whole snapshot, skipped words included
  always_comb begin
    csum = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) csum = csum ^ snap[i];
  end
`endif

endmodule

// File: rtl/reg_dump_streamer.sv
// Register-dump streamer: snapshots the flattened register-file debug bus on
// start and emits one (index, value) entry per valid/ready transfer,
// optionally omitting zero-valued registers.
// Optional feature macro: REG_DUMP_CHECKSUM_EN (trailing XOR checksum entry
// at index NUM_REGS).
module reg_dump_streamer
  import reg_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       skip_zero,
  input  logic [NUM_REGS*DATA_W-1:0] reg_debug,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [IDX_W-1:0]           out_index,
  output logic                       busy,
  output logic                       done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              mode, mode_nxt;
  logic              out_valid_nxt, busy_nxt, done_nxt;
  logic [DATA_W-1:0] out_data_nxt;
  logic [IDX_W-1:0]  out_index_nxt;
  logic              capture_c;
  logic              wrap_c;
  logic [DATA_W-1:0] snap_word;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_word;
`endif

  reg_dump_snapshot #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W)
  ) u_snapshot (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture_c),
    .reg_debug (reg_debug),
    .rd_index  (idx),
    .rd_data   (snap_word)
`ifdef REG_DUMP_CHECKSUM_EN
    ,
    .csum      (csum_word)
`endif
  );

  // Next-state and next-output logic; wrap_c marks "last register handled"
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    mode_nxt      = mode;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    out_index_nxt = out_index;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    capture_c     = 1'b0;
    wrap_c        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          capture_c = 1'b1;
          mode_nxt  = skip_zero;
          idx_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (mode && (snap_word == '0)) begin
          if (idx == LAST_IDX) wrap_c = 1'b1;
          else                 idx_nxt = idx + IDX_W'(1);
        end else begin
          out_data_nxt  = snap_word;
          out_index_nxt = idx;
          out_valid_nxt = 1'b1;
          state_nxt     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          if (idx == LAST_IDX) begin
            wrap_c = 1'b1;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = ST_SCAN;
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          done_nxt      = 1'b1;
          busy_nxt      = 1'b0;
          state_nxt     = ST_FINISH;
        end
      end
`endif
      ST_FINISH: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (wrap_c) begin
`ifdef REG_DUMP_CHECKSUM_EN
      out_data_nxt  = csum_word;
      out_index_nxt = IDX_W'(NUM_REGS);
      out_valid_nxt = 1'b1;
      state_nxt     = ST_CSUM;
`else
      done_nxt  = 1'b1;
      busy_nxt  = 1'b0;
      state_nxt = ST_FINISH;
`endif
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      mode      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      mode      <= mode_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_index <= out_index_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Self-checking bench for reg_dump_streamer. Expected entry streams come from
// a queue-based model built from the bus contents at start time.
// Honours REG_DUMP_CHECKSUM_EN when the design is built with it.
module tb_reg_dump_streamer;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned IDX_W    = $clog2(NUM_REGS + 1);
  localparam int unsigned BUS_W    = NUM_REGS * DATA_W;

  typedef struct {
    int unsigned idx;
    logic [31:0] data;
  } entry_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              skip_zero;
  logic [BUS_W-1:0]  reg_debug;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_index;
  logic              busy;
  logic              done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reg_dump_streamer #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .skip_zero (skip_zero),
    .reg_debug (reg_debug),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BUS_W-1:0] rand_bus(input bit zeros);
    logic [BUS_W-1:0] b;
    logic [31:0]      w;
    b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w = $urandom;
      if (zeros && ($urandom_range(0, 2) == 0)) w = '0;
      if (!zeros && (w == 0)) w = 32'h1;
      b[i*DATA_W +: DATA_W] = w;
    end
    return b;
  endfunction

  // One complete dump: model, start pulse, handshake loop, post-dump quiet check.
  // rmode: 0 = ready always, 1 = ready one cycle in three, 2 = random ready.
  task automatic run_dump(input bit skip, input int rmode, input bit scramble,
                          input bit restart, input bit chk_lat);
    entry_t      exp_q[$];
    entry_t      e;
    logic [31:0] w;
    logic [31:0] csum;
    int          nsent, nskip, cyc, lat;
    bit          first_sent, held, got_done, r;
    logic [31:0] hd;
    logic [IDX_W-1:0] hi;

    csum = '0; nsent = 0; nskip = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w = reg_debug[i*DATA_W +: DATA_W];
      csum = csum ^ w;
      if (skip && (w == 0)) nskip++;
      else begin
        e.idx = i; e.data = w; exp_q.push_back(e); nsent++;
      end
    end
`ifdef REG_DUMP_CHECKSUM_EN
    e.idx = NUM_REGS; e.data = csum; exp_q.push_back(e);
    lat = 2 + 2 * nsent + nskip;
`else
    lat = 1 + 2 * nsent + nskip;
`endif
    first_sent = !(skip && (reg_debug[DATA_W-1:0] == 0));

    skip_zero = skip;
    start     = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    cyc      = 1;
    held     = 0;
    got_done = 0;
    check("busy_after_start", busy, 1'b1);
    while (!got_done && cyc < 500) begin
      if (chk_lat && cyc == 2 && first_sent) begin
        check("first_valid", out_valid, 1'b1);
        check("first_index", out_index, 0);
      end
      if (done) begin
        got_done = 1;
        check("done_queue_empty", exp_q.size(), 0);
        check("busy_at_done", busy, 1'b0);
        if (chk_lat) check("done_latency", cyc, lat);
        start = restart;
      end else begin
        if (held) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_data", out_data, hd);
          check("hold_index", out_index, hi);
        end
        case (rmode)
          0:       r = 1'b1;
          1:       r = (cyc % 3 == 0);
          default: r = 1'($urandom_range(0, 1));
        endcase
        out_ready = r;
        if (out_valid) begin
          if (r) begin
            held = 0;
            if (exp_q.size() == 0) check("extra_entry_index", out_index, 'hFF);
            else begin
              e = exp_q.pop_front();
              check($sformatf("index[%0d]", e.idx), out_index, e.idx);
              check($sformatf("data[%0d]", e.idx), out_data, e.data);
            end
          end else begin
            held = 1; hd = out_data; hi = out_index;
          end
        end
        if (scramble) reg_debug = rand_bus(1'b0);
        start = restart && (cyc == 7);
        @(negedge clk);
        cyc++;
      end
    end
    if (!got_done) check("done_timeout", got_done, 1'b1);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      check("post_done", done, 1'b0);
      check("post_valid", out_valid, 1'b0);
      check("post_busy", busy, 1'b0);
    end
  endtask

  initial begin
    bit found;
    reset     = 1'b1;
    start     = 1'b0;
    skip_zero = 1'b0;
    out_ready = 1'b0;
    reg_debug = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_data", out_data, 0);
    check("rst_index", out_index, 0);
    reset = 1'b0;
    @(negedge clk);

    // Ascending pattern, ready always high
    for (int i = 0; i < NUM_REGS; i++) reg_debug[i*DATA_W +: DATA_W] = 32'h100 + 32'(i);
    run_dump(1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Same pattern with ready one cycle in three
    run_dump(1'b0, 1, 1'b0, 1'b0, 1'b0);

    // Sparse bus with skip mode
    reg_debug = '0;
    reg_debug[2*DATA_W +: DATA_W]  = 32'hDEADBEEF;
    reg_debug[31*DATA_W +: DATA_W] = 32'h00000001;
    run_dump(1'b1, 0, 1'b0, 1'b0, 1'b1);

    // Bus churns during the dump; start re-pulsed mid-dump and in FINISH
    reg_debug = rand_bus(1'b0);
    run_dump(1'b0, 2, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset while index 10 waits on ready
    reg_debug = rand_bus(1'b0);
    skip_zero = 1'b0;
    out_ready = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (out_valid && out_index == 10) begin
        found = 1;
        out_ready = 1'b0;
      end else @(negedge clk);
    end
    check("reach_index10", found, 1'b1);
    @(negedge clk);
    check("wait_index10", out_index, 10);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_index", out_index, 0);
    @(negedge clk);
    check("arst_hold_done", done, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    run_dump(1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Random data with zeros, random skip and ready
    for (int t = 0; t < 4; t++) begin
      reg_debug = rand_bus(1'b1);
      run_dump(1'(t % 2 == 0), 2, 1'b0, 1'b0, 1'b0);
    end

    // All-zero bus: skip mode emits nothing, normal mode emits 32 zeros
    reg_debug = '0;
    run_dump(1'b1, 0, 1'b0, 1'b0, 1'b1);
    run_dump(1'b0, 0, 1'b0, 1'b0, 1'b1);

`ifdef REG_DUMP_CHECKSUM_EN
    // Checksum entry: reg i = i, then reg 5 replaced
    for (int i = 0; i < NUM_REGS; i++) reg_debug[i*DATA_W +: DATA_W] = 32'(i);
    run_dump(1'b0, 0, 1'b0, 1'b0, 1'b1);
    reg_debug[5*DATA_W +: DATA_W] = 32'hFFFF0000;
    run_dump(1'b1, 1, 1'b0, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_dump_streamer.md
Name: reg_dump_streamer

Overview:
Captures a coherent snapshot of the CPU's flattened register-file debug bus on a start pulse. Streams the snapshot out one register per transfer over a valid/ready interface, tagged with its register index. Feeds the UART/video debug path and the self-checking simulation harness. Generalised over register count and width, with an optional skip-zero mode.

Parameters:
NUM_REGS, 32, number of registers packed in the debug bus
DATA_W, 32, width of each register in bits
IDX_W, $clog2(NUM_REGS+1), width of the index output (derived; room for index NUM_REGS)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to snapshot and dump
skip_zero  input  1  sampled with start; 1 = omit registers whose snapshot value is 0
reg_debug  input  NUM_REGS*DATA_W  flattened registers; reg i occupies bits [(i+1)*DATA_W-1 : i*DATA_W]
out_valid  output  1  out_data/out_index hold a valid entry
out_ready  input  1  downstream accepts the entry when high with out_valid
out_data  output  DATA_W  register value from the snapshot
out_index  output  IDX_W  register number of out_data
busy  output  1  dump in progress (start ignored)
done  output  1  one-cycle pulse after the final transfer

Behaviour:
- Reset (async, any state, including mid-dump): state=IDLE, out_valid=0, out_data=0, out_index=0, busy=0, done=0, snapshot cleared. An interrupted dump never emits done.
- IDLE: on start=1, the snapshot register latches all of reg_debug and the mode latches skip_zero. idx=0, state=SCAN, busy=1 on the next cycle. Later changes to reg_debug do not affect the dump.
- SCAN (one cycle per register, out_valid=0):
  - If mode=skip and snap[idx]==0: if idx==NUM_REGS-1, go to FINISH; else idx++ and stay in SCAN.
  - Otherwise load out_data=snap[idx], out_index=idx, assert out_valid, go to SEND.
- SEND: out_valid, out_data and out_index are held stable until out_valid&&out_ready.
  - On transfer, out_valid drops next cycle.
  - If idx==NUM_REGS-1, go to FINISH; else idx++ and return to SCAN.
- FINISH: done=1 for exactly one cycle, busy=0, state=IDLE. A start in this cycle is ignored.
- Latency: start at edge N gives out_valid high after edge N+2. With out_ready tied high and no skips, each entry takes 2 cycles, so a full dump is 2*NUM_REGS+1 cycles from start to done.
- start while busy=1 is ignored; no queueing.
- All registers zero with skip mode: no transfers; done pulses after NUM_REGS SCAN cycles.
- Register 0 is not special; it is skipped only by the zero rule.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- Defined: after the last register entry, one extra entry is emitted with out_index=NUM_REGS and out_data = XOR of all NUM_REGS snapshot words. The checksum covers skipped words too and is never skipped itself. done follows the checksum transfer.
- Undefined: no checksum entry and no XOR logic; index NUM_REGS is never produced.

Decomposition:
- Shared package reg_dump_pkg holds:
  - state enum (IDLE, SCAN, SEND, FINISH; plus CSUM when the feature is enabled);
  - the default NUM_REGS/DATA_W constants, shared with the CPU debug bus;
  - a function that extracts the word at an index from the flat bus.
- One natural sub-module, reg_dump_snapshot: the NUM_REGS x DATA_W capture register with indexed read mux and XOR reduction. The FSM and handshake stay in the top.

Test Plan:
- Reg i = 0x100+i, out_ready=1, skip_zero=0, pulse start → 32 transfers with index 0..31 and data 0x100..0x11F in order; done one cycle after the last transfer; busy low afterwards.
- out_ready toggled as a 1-of-3 pattern → out_data/out_index stay constant while waiting; no entry is lost or duplicated; same 32-entry sequence.
- Only regs 2=0xDEADBEEF and 31=0x1 nonzero, skip_zero=1 → exactly 2 transfers: (2, 0xDEADBEEF) then (31, 0x00000001), then done.
- Change reg_debug every cycle during the dump and pulse start again mid-dump → stream equals the values at the first start; the second start is ignored; one done only.
- Assert reset while index 10 is waiting on out_ready=0 → out_valid, busy and done are 0 immediately (async); a new start gives a full dump from index 0.
- With REG_DUMP_CHECKSUM_EN and reg i = i → entry 33 has out_index=32 and out_data = XOR(0..31) = 0x00000000. With reg 5 changed to 0xFFFF0000, the checksum is 0xFFFF0005.
